// File: rtl/txt_ram_arb_if.sv
`timescale 1ns/1ps
// txt_ram_arb_if: client-side REQ/ACK bus of the text RAM arbiter.
// Four clients are packed side by side; client i owns ADDR[12i+11:12i],
// WDATA[7i+6:7i] and bit i of every per-client vector.
interface txt_ram_arb_if;
  logic [3:0]  REQ;
  logic [3:0]  RW;
  logic [47:0] ADDR;
  logic [27:0] WDATA;
  logic [3:0]  ACK;
  logic [3:0]  RVALID;
  logic [6:0]  RDATA;

  modport master (
    output REQ, RW, ADDR, WDATA,
    input  ACK, RVALID, RDATA
  );

  modport slave (
    input  REQ, RW, ADDR, WDATA,
    output ACK, RVALID, RDATA
  );
endinterface

// File: rtl/txt_ram_arb.sv
`timescale 1ns/1ps
// txt_ram_arb: shares the single-port text RAM between four REQ/ACK clients and
// the VGA character fetch. Fetch slots are fixed by the raster position and always
// win; every other cycle goes to one eligible client, chosen round-robin (RR=1) or
// by fixed priority with client 0 highest (RR=0). A two-stage tag pipeline follows
// each RAM access so the registered read data is steered to VGA_TXT or RDATA.
module txt_ram_arb #(
  parameter bit RR = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [9:0]   VGA_HC,
  input  logic [9:0]   VGA_VC,
  txt_ram_arb_if.slave bus,
  output logic         RAM_WE,
  output logic [11:0]  RAM_ADDR,
  output logic [6:0]   RAM_DIN,
  input  logic [6:0]   RAM_DOUT,
  output logic [6:0]   VGA_TXT
);

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_VGA    = 2'd1,
    SLOT_CLIENT = 2'd2
  } slot_e;

  typedef struct packed {
    logic       vga;
    logic       rd;
    logic [1:0] idx;
  } tag_t;

  logic        w_vgaMid;
  logic        w_vgaEol;
  logic [4:0]  w_nextRow;
  logic [6:0]  w_nextCol;
  logic [11:0] w_vgaAddr;
  logic [3:0]  w_elig;
  logic [1:0]  w_cand;
  logic [1:0]  w_pick;
  logic [11:0] w_clientAddr;
  logic [6:0]  w_clientData;
  slot_e       w_slot;

  logic [3:0]  r_ack;
  logic [3:0]  r_rvalid;
  logic [6:0]  r_rdata;
  logic        r_ramWe;
  logic [11:0] r_ramAddr;
  logic [6:0]  r_ramDin;
  logic [6:0]  r_vgaTxt;
  logic [1:0]  r_lastGrant;
  tag_t        r_tag1;
  tag_t        r_tag2;

  // Classify the sampled raster position and build the character fetch address
  // (next column mid-line, column 0 of the following text line at end of line).
  always_comb begin
    w_vgaMid  = (VGA_HC[2:0] == 3'd7) && (VGA_HC < 10'd632) && (VGA_VC < 10'd480);
    w_vgaEol  = (VGA_HC == 10'd799) && ((VGA_VC < 10'd479) || (VGA_VC == 10'd524));
    w_nextRow = 5'd0;
    if (VGA_VC != 10'd524) begin
      w_nextRow = 5'((VGA_VC + 10'd1) >> 4);
    end
    w_nextCol = VGA_HC[9:3] + 7'd1;
    w_vgaAddr = w_vgaEol ? {w_nextRow, 7'd0} : {VGA_VC[8:4], w_nextCol};
  end

  // Pick the winning client; a client whose ACK is high this cycle is masked so a
  // held REQ cannot be granted twice. Also decide what the next edge does with the RAM.
  always_comb begin
    w_elig       = bus.REQ & ~r_ack;
    w_pick       = 2'd0;
    w_cand       = 2'd0;
    w_clientAddr = 12'd0;
    w_clientData = 7'd0;
    w_slot       = SLOT_IDLE;
    if (RR) begin
      for (int k = 4; k >= 1; k--) begin
        w_cand = r_lastGrant + 2'(k);
        if (w_elig[w_cand]) begin
          w_pick = w_cand;
        end
      end
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (w_elig[k]) begin
          w_pick = 2'(k);
        end
      end
    end
    case (w_pick)
      2'd0: begin
        w_clientAddr = bus.ADDR[11:0];
        w_clientData = bus.WDATA[6:0];
      end
      2'd1: begin
        w_clientAddr = bus.ADDR[23:12];
        w_clientData = bus.WDATA[13:7];
      end
      2'd2: begin
        w_clientAddr = bus.ADDR[35:24];
        w_clientData = bus.WDATA[20:14];
      end
      default: begin
        w_clientAddr = bus.ADDR[47:36];
        w_clientData = bus.WDATA[27:21];
      end
    endcase
    if (w_vgaMid || w_vgaEol) begin
      w_slot = SLOT_VGA;
    end else if (|w_elig) begin
      w_slot = SLOT_CLIENT;
    end
  end

  // Drive the RAM port, the grant pulse and the round-robin pointer for this slot;
  // an idle cycle only drops the write enable and leaves address/data where they were.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ack       <= 4'd0;
      r_ramWe     <= 1'b0;
      r_ramAddr   <= 12'd0;
      r_ramDin    <= 7'd0;
      r_lastGrant <= 2'd3;
      r_tag1      <= '0;
    end else begin
      r_ack   <= 4'd0;
      r_ramWe <= 1'b0;
      r_tag1  <= '0;
      case (w_slot)
        SLOT_VGA: begin
          r_ramAddr <= w_vgaAddr;
          r_tag1    <= {1'b1, 1'b0, 2'd0};
        end
        SLOT_CLIENT: begin
          r_ack       <= 4'b0001 << w_pick;
          r_ramAddr   <= w_clientAddr;
          r_ramWe     <= bus.RW[w_pick];
          r_ramDin    <= w_clientData;
          r_lastGrant <= w_pick;
          r_tag1      <= {1'b0, ~bus.RW[w_pick], w_pick};
        end
        default: begin
        end
      endcase
    end
  end

  // Age the access tags and, two edges after the access, capture RAM_DOUT for
  // whoever owns it; reset flushes the tags so an in-flight read never returns.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tag2   <= '0;
      r_rvalid <= 4'd0;
      r_rdata  <= 7'd0;
      r_vgaTxt <= 7'd0;
    end else begin
      r_tag2   <= r_tag1;
      r_rvalid <= 4'd0;
      if (r_tag2.rd) begin
        r_rvalid <= 4'b0001 << r_tag2.idx;
        r_rdata  <= RAM_DOUT;
      end
      if (r_tag2.vga) begin
        r_vgaTxt <= RAM_DOUT;
      end
    end
  end

  assign bus.ACK    = r_ack;
  assign bus.RVALID = r_rvalid;
  assign bus.RDATA  = r_rdata;
  assign RAM_WE     = r_ramWe;
  assign RAM_ADDR   = r_ramAddr;
  assign RAM_DIN    = r_ramDin;
  assign VGA_TXT    = r_vgaTxt;

endmodule

// File: tb/tb_txt_ram_arb.sv
`timescale 1ns/1ps
// tb_txt_ram_arb: directed and randomized checks of the text RAM arbiter against a
// cycle-level reference model (raster arithmetic, a shadow memory and a queue of
// in-flight reads). A second instance runs in fixed-priority mode.
module tb_txt_ram_arb;

  typedef struct {
    int         due;
    bit         vga;
    int         idx;
    logic [6:0] data;
  } pend_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [9:0]  hc, vc;
  logic [3:0]  req, rw;
  logic [47:0] addr;
  logic [27:0] wdata;
  logic        RAM_WE;
  logic [11:0] RAM_ADDR;
  logic [6:0]  RAM_DIN, RAM_DOUT, VGA_TXT;

  logic [3:0]  fReq;
  logic [9:0]  fpHc = 10'd700;
  logic [9:0]  fpVc = 10'd500;
  logic        fpWe;
  logic [11:0] fpAddr;
  logic [6:0]  fpDin, fpTxt;
  logic [6:0]  fpDout = 7'd0;

  logic [6:0]  ramMem [4096];
  bit          ramReady = 1'b0;

  int          nVec, nMis, cyc;
  int          waitCnt [4];
  pend_t       pend [$];
  logic [6:0]  refMem [4096];
  int          mLast;
  logic [3:0]  mAck, mRvalid, fAck;
  logic        mWe;
  logic [11:0] mAddr;
  logic [6:0]  mDin, mTxt, mRdata;

  txt_ram_arb_if bus();
  txt_ram_arb_if fpBus();

  assign bus.REQ     = req;
  assign bus.RW      = rw;
  assign bus.ADDR    = addr;
  assign bus.WDATA   = wdata;
  assign fpBus.REQ   = fReq;
  assign fpBus.RW    = 4'hF;
  assign fpBus.ADDR  = 48'h0;
  assign fpBus.WDATA = 28'h0;

  always #20 CLK = ~CLK;

  txt_ram_arb #(.RR(1'b1)) dut (
    .CLK(CLK), .RST(RST), .VGA_HC(hc), .VGA_VC(vc), .bus(bus),
    .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN),
    .RAM_DOUT(RAM_DOUT), .VGA_TXT(VGA_TXT)
  );

  txt_ram_arb #(.RR(1'b0)) dutFp (
    .CLK(CLK), .RST(RST), .VGA_HC(fpHc), .VGA_VC(fpVc), .bus(fpBus),
    .RAM_WE(fpWe), .RAM_ADDR(fpAddr), .RAM_DIN(fpDin),
    .RAM_DOUT(fpDout), .VGA_TXT(fpTxt)
  );

  function automatic logic [6:0] initVal(int a);
    return 7'((a * 37 + (a >> 5)) ^ 8'h2A);
  endfunction

  // Single-port text RAM with one cycle of registered read latency.
  always @(posedge CLK) begin
    if (!ramReady) begin
      for (int i = 0; i < 4096; i++) ramMem[i] <= initVal(i);
      ramReady <= 1'b1;
    end else begin
      if (RAM_WE) ramMem[RAM_ADDR] <= RAM_DIN;
      RAM_DOUT <= ramMem[RAM_ADDR];
    end
  end

  task automatic check(string tag, logic [47:0] obs, logic [47:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the RR instance for one edge, from the inputs sampled at it.
  task automatic modelMain(bit r, int h, int v, logic [3:0] rq, logic [3:0] rwv,
                           logic [47:0] ad, logic [27:0] wd);
    bit         slot;
    int         a, win;
    logic [3:0] elig;
    logic [11:0] ca;
    if (r) begin
      mAck = 4'd0; mWe = 1'b0; mAddr = 12'd0; mDin = 7'd0;
      mRvalid = 4'd0; mRdata = 7'd0; mTxt = 7'd0; mLast = 3;
      pend.delete();
      return;
    end
    mRvalid = 4'd0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == cyc) begin
        if (pend[i].vga) mTxt = pend[i].data;
        else begin
          mRvalid = 4'(1 << pend[i].idx);
          mRdata  = pend[i].data;
        end
        pend.delete(i);
      end
    end
    slot = ((h % 8) == 7 && h < 632 && v < 480) || (h == 799 && (v < 479 || v == 524));
    if (slot) begin
      if (h == 799) a = ((v == 524 ? 0 : v + 1) / 16) * 128;
      else          a = (v / 16) * 128 + h / 8 + 1;
      mAck = 4'd0; mWe = 1'b0; mAddr = 12'(a);
      pend.push_back('{due: cyc + 2, vga: 1'b1, idx: 0, data: refMem[12'(a)]});
    end else begin
      elig = rq & ~mAck;
      mAck = 4'd0; mWe = 1'b0;
      if (elig != 4'd0) begin
        win = -1;
        for (int k = 1; k <= 4; k++) begin
          if (win < 0 && elig[(mLast + k) % 4]) win = (mLast + k) % 4;
        end
        ca    = ad[12 * win +: 12];
        mAck  = 4'(1 << win);
        mAddr = ca;
        mWe   = rwv[win];
        mDin  = wd[7 * win +: 7];
        mLast = win;
        if (rwv[win]) refMem[ca] = wd[7 * win +: 7];
        else pend.push_back('{due: cyc + 2, vga: 1'b0, idx: win, data: refMem[ca]});
      end
    end
  endtask

  // Fixed-priority instance model: lowest eligible index wins, no VGA slots at HC=700.
  task automatic modelFp(bit r, logic [3:0] rq);
    logic [3:0] elig;
    bit found;
    if (r) begin
      fAck = 4'd0;
      return;
    end
    elig = rq & ~fAck;
    fAck = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && elig[i]) begin
        fAck = 4'(1 << i);
        found = 1'b1;
      end
    end
  endtask

  task automatic step();
    bit          sRst;
    int          sHc, sVc;
    logic [3:0]  sReq, sRw, sFReq;
    logic [47:0] sAddr;
    logic [27:0] sWd;
    sRst = RST; sHc = int'(hc); sVc = int'(vc);
    sReq = req; sRw = rw; sAddr = addr; sWd = wdata; sFReq = fReq;
    @(posedge CLK);
    #1;
    cyc++;
    modelMain(sRst, sHc, sVc, sReq, sRw, sAddr, sWd);
    modelFp(sRst, sFReq);
    check("ACK", 48'(bus.ACK), 48'(mAck));
    check("RAM_WE", 48'(RAM_WE), 48'(mWe));
    check("RAM_ADDR", 48'(RAM_ADDR), 48'(mAddr));
    if (mWe || sRst) check("RAM_DIN", 48'(RAM_DIN), 48'(mDin));
    check("RVALID", 48'(bus.RVALID), 48'(mRvalid));
    check("RDATA", 48'(bus.RDATA), 48'(mRdata));
    check("VGA_TXT", 48'(VGA_TXT), 48'(mTxt));
    check("FP ACK", 48'(fpBus.ACK), 48'(fAck));
  endtask

  task automatic tick();
    step();
    if (hc == 10'd799) begin
      hc = 10'd0;
      vc = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
    end else begin
      hc = hc + 10'd1;
    end
  endtask

  task automatic setClient(int i, bit r, bit w, logic [11:0] a, logic [6:0] d);
    req[i] = r;
    rw[i]  = w;
    addr[12 * i +: 12] = a;
    wdata[7 * i +: 7]  = d;
  endtask

  task automatic newReq(int i);
    setClient(i, 1'b1, 1'($urandom_range(1)), 12'($urandom), 7'($urandom));
  endtask

  task automatic clientTicks(int n, int maxWait, int raisePct, bit orderCheck);
    int prevGrant;
    logic [3:0] prevAck;
    prevGrant = mLast;
    prevAck = 4'd0;
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && int'($urandom_range(99)) < raisePct) begin
          newReq(i);
          waitCnt[i] = 0;
        end
      end
      tick();
      check("no back-to-back ACK", 48'(bus.ACK & prevAck), 48'(0));
      prevAck = bus.ACK;
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          waitCnt[i]++;
          if (bus.ACK[i]) begin
            check("grant latency", 48'(waitCnt[i] <= maxWait), 48'(1));
            if (orderCheck) begin
              check("RR order", 48'(i), 48'((prevGrant + 1) % 4));
              prevGrant = i;
            end
            waitCnt[i] = 0;
            if (raisePct >= 100 || $urandom_range(1) == 0) newReq(i);
            else req[i] = 1'b0;
          end
        end
      end
    end
  endtask

  initial begin
    nVec = 0; nMis = 0; cyc = 0;
    RST = 1'b1; hc = 10'd700; vc = 10'd500;
    req = 4'd0; rw = 4'd0; addr = 48'd0; wdata = 28'd0; fReq = 4'd0;
    for (int i = 0; i < 4; i++) waitCnt[i] = 0;
    for (int i = 0; i < 4096; i++) refMem[i] = initVal(i);

    // Reset state.
    step();
    step();
    check("reset ACK", 48'(bus.ACK), 48'(0));
    check("reset RAM_ADDR", 48'(RAM_ADDR), 48'(0));
    RST = 1'b0;

    // Single write then read by client 2 in blanking.
    setClient(2, 1'b1, 1'b1, 12'h123, 7'h41);
    step();
    check("wr ACK", 48'(bus.ACK), 48'(4'b0100));
    check("wr RAM_WE", 48'(RAM_WE), 48'(1));
    rw[2] = 1'b0;
    step();
    check("re-raise masked", 48'(bus.ACK), 48'(0));
    step();
    check("rd ACK", 48'(bus.ACK), 48'(4'b0100));
    req[2] = 1'b0;
    step();
    step();
    check("rd RVALID", 48'(bus.RVALID), 48'(4'b0100));
    check("rd RDATA", 48'(bus.RDATA), 48'(7'h41));

    // Round-robin fairness with all four clients requesting.
    clientTicks(16, 4, 100, 1'b1);
    req = 4'd0;
    step();
    step();
    step();

    // VGA slot preemption at HC=103, VC=16.
    vc = 10'd16; hc = 10'd102;
    step();
    hc = 10'd103;
    setClient(0, 1'b1, 1'b0, 12'h2A5, 7'h00);
    step();
    check("slot RAM_ADDR", 48'(RAM_ADDR), 48'(12'h08D));
    check("slot RAM_WE", 48'(RAM_WE), 48'(0));
    check("slot ACK", 48'(bus.ACK), 48'(0));
    hc = 10'd104;
    step();
    check("post-slot ACK", 48'(bus.ACK), 48'(4'b0001));
    req[0] = 1'b0;
    hc = 10'd105;
    step();
    check("slot VGA_TXT", 48'(VGA_TXT), 48'(refMem[12'h08D]));
    hc = 10'd106;
    step();
    check("c0 RDATA", 48'(bus.RDATA), 48'(refMem[12'h2A5]));

    // Line and frame wrap fetches.
    hc = 10'd799; vc = 10'd15;
    step();
    check("eol VC=15 addr", 48'(RAM_ADDR), 48'(12'h080));
    vc = 10'd479;
    setClient(1, 1'b1, 1'b1, 12'h333, 7'h55);
    step();
    check("VC=479 no slot", 48'(bus.ACK), 48'(4'b0010));
    req[1] = 1'b0;
    vc = 10'd524;
    step();
    check("VC=524 addr", 48'(RAM_ADDR), 48'(12'h000));
    check("VC=524 ACK", 48'(bus.ACK), 48'(0));
    hc = 10'd700; vc = 10'd500;
    step();
    step();
    step();

    // Reset in the middle of a client 1 read.
    setClient(1, 1'b1, 1'b0, 12'h123, 7'h00);
    step();
    check("c1 rd ACK", 48'(bus.ACK), 48'(4'b0010));
    RST = 1'b1;
    req = 4'd0;
    step();
    check("rst ACK", 48'(bus.ACK), 48'(0));
    check("rst RVALID", 48'(bus.RVALID), 48'(0));
    check("rst RDATA", 48'(bus.RDATA), 48'(0));
    check("rst RAM_WE", 48'(RAM_WE), 48'(0));
    check("rst RAM_ADDR", 48'(RAM_ADDR), 48'(0));
    check("rst RAM_DIN", 48'(RAM_DIN), 48'(0));
    check("rst VGA_TXT", 48'(VGA_TXT), 48'(0));
    RST = 1'b0;
    req = 4'hF;
    step();
    check("dropped read RVALID", 48'(bus.RVALID), 48'(0));
    check("first RR grant", 48'(bus.ACK), 48'(4'b0001));
    req = 4'd0;
    step();
    step();

    // Fixed priority: clients 1 and 3 requesting continuously.
    fReq = 4'b1010;
    for (int j = 0; j < 8; j++) begin
      step();
      check("FP pattern", 48'(fpBus.ACK), 48'((j % 2 == 0) ? 4'b0010 : 4'b1000));
    end
    fReq = 4'd0;
    step();

    // Randomized clients across active video, line ends and the frame wrap.
    for (int i = 0; i < 4; i++) waitCnt[i] = 0;
    vc = 10'd14; hc = 10'd560;
    clientTicks(600, 6, 30, 1'b0);
    vc = 10'd478; hc = 10'd790;
    clientTicks(40, 6, 30, 1'b0);
    vc = 10'd524; hc = 10'd790;
    clientTicks(40, 6, 30, 1'b0);
    req = 4'd0;
    step();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/txt_ram_arb.md
# txt_ram_arb

Arbiter and sequencer for the single-port text RAM behind the VGA text display. It shares the RAM port between four client ports (keyboard echo, UART read-back, probe text, SPI text-memory load/readback) and the VGA character fetch. VGA fetch slots are reserved and never delayed. Client accesses use a REQ/ACK handshake with round-robin or fixed priority. The block sits between the client state machines and the RAM, on the 25 MHz pixel clock.

## Interface
- `RR`, default 1: 1 selects round-robin among clients; 0 selects fixed priority, client 0 highest.
- `CLK`  in  1  25 MHz pixel clock; all logic on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `VGA_HC`  in  10  horizontal pixel counter, 0..799.
- `VGA_VC`  in  10  vertical line counter, 0..524.
- `REQ`  in  4  per-client request; held until ACK.
- `RW`  in  4  per-client direction; 1 = write, 0 = read.
- `ADDR`  in  48  client i address is `ADDR[12i+11:12i]`; format {row[4:0], col[6:0]}.
- `WDATA`  in  28  client i write data is `WDATA[7i+6:7i]`.
- `ACK`  out  4  one-hot, one-cycle grant pulse.
- `RVALID`  out  4  one-hot, one-cycle read-data-valid pulse.
- `RDATA`  out  7  read data; valid while `RVALID` is non-zero.
- `RAM_WE`  out  1  RAM write enable.
- `RAM_ADDR`  out  12  RAM address.
- `RAM_DIN`  out  7  RAM write data.
- `RAM_DOUT`  in  7  RAM read data; 1-cycle registered latency.
- `VGA_TXT`  out  7  character code for the next display column.

## Operation
- **Slot classification.** Every cycle is evaluated on the sampled `VGA_HC`/`VGA_VC`; it is either a VGA slot or a client slot.
- **VGA slot, mid-line.** Condition: `HC[2:0]==7`, `HC<632`, `VC<480`. Fetch address = {`VC[8:4]`, `HC[9:3]+1`}.
- **VGA slot, end of line.** Condition: `HC==799` and (`VC<479` or `VC==524`). Fetch address = {row of next line, col 0}.
  - Next-line row is `(VC+1)[8:4]`.
  - When `VC==524`, the row wraps to 0.
- **VGA slot effects.** Next edge drives `RAM_ADDR` with the fetch address and `RAM_WE`=0. No client is granted.
- **Client slot, eligibility.** Eligible clients are `REQ[i]=1` and `ACK[i]=0`. Masking a client whose `ACK` is currently high prevents double-grant of a held REQ.
- **Arbitration.** RR=1: search starts at `last_grant+1` mod 4. RR=0: lowest index wins.
- **Grant.** The next edge registers `ACK[i]`=1, `RAM_ADDR`=`ADDR_i`, `RAM_WE`=`RW[i]`, `RAM_DIN`=`WDATA_i`.
  - `last_grant` updates only on a grant.
- **Idle.** With no eligible client, `RAM_WE`=0 and `RAM_ADDR` holds its previous value.
- **Read return.** Read data returns on `RDATA`/`RVALID[i]` two edges after `ACK[i]`.
- **VGA return.** VGA fetch data is latched into `VGA_TXT` two edges after the slot edge.
- **Pipeline tags.** A 2-stage tag pipeline {vga, rd, idx[1:0]} follows every RAM access.
- **Reset.** `ACK`=0, `RVALID`=0, `RDATA`=0, `RAM_WE`=0, `RAM_ADDR`=0, `RAM_DIN`=0, `VGA_TXT`=0.
  - `last_grant`=3, so client 0 is first in RR mode.
  - The tag pipeline is flushed.
  - A reset during an access drops it silently; a pending read returns no `RVALID`.

## Timing
- Slot-decision cycle t, sampled at edge E0 → RAM access driven during cycle t+1 → `RAM_DOUT` valid in cycle t+2 → `RDATA`/`VGA_TXT` registered at edge E2 (visible in cycle t+3).
- `ACK` is high during cycle t+1, concurrent with the RAM access. A write is committed by the RAM at edge E1.
- The client must hold `REQ`/`RW`/`ADDR`/`WDATA` stable until it samples `ACK`=1, and may drop or re-raise `REQ` in the `ACK` cycle.
  - A re-raised request is ineligible in that cycle and eligible from the next.
  - A single client therefore gets at most one grant every 2 cycles.
- Client throughput: 7 of every 8 cycles during active lines; all cycles during blanking.
- Worst-case client latency, RR=1, all 4 requesting: 2 VGA slots + 3 other grants → at most 6 cycles from `REQ` to `ACK`.
  - RR=0 gives no bound for client 3.
- Simultaneous VGA slot and client request: VGA always wins; the client waits without loss.
- `RVALID` and `VGA_TXT` updates never collide, because the tag pipeline carries exactly one access per cycle.

## Test plan
- **Single write/read, mid-blanking.** Reset, HC=700, VC=500. Client 2 writes addr 0x123, data 0x41 (REQ t0). Then client 2 reads addr 0x123.
  - Required: `ACK[2]` in t1 with `RAM_WE`=1.
  - Required: read `ACK[2]` followed 2 edges later by `RVALID`=4'b0100 and `RDATA`=0x41.
- **Round-robin fairness.** All four clients hold `REQ` continuously during blanking, RR=1.
  - Required: grant order 0,1,2,3,0,…
  - Required: no `ACK[i]` in two consecutive cycles.
  - Required: no client waits more than 4 cycles.
- **VGA slot preemption.** VC=16. Client 0 raises `REQ` in the cycle with HC=103.
  - Required: cycle t+1 carries `RAM_ADDR`={5'd1, 7'd13} with `RAM_WE`=0 and `ACK`=0.
  - Required: `ACK[0]` follows in the next cycle.
  - Required: `VGA_TXT` equals the RAM content at 0x08D two edges after the slot.
- **Line/frame wrap.** HC=799 with VC=15, then VC=479, then VC=524.
  - Required: fetch address {5'd1, 0} when VC=15.
  - Required: no VGA slot when VC=479.
  - Required: fetch address {5'd0, 0} when VC=524.
- **Reset mid-read.** Client 1 read granted (`ACK[1]`); assert `RST` on the next edge.
  - Required: `RVALID` stays 0.
  - Required: all outputs 0 in the cycle after reset.
  - Required: the first RR grant after release goes to client 0.
- **Fixed priority.** RR=0; clients 1 and 3 both requesting.
  - Required: client 1 is granted every other cycle.
  - Required: client 3 is granted only in the cycles where client 1 is masked by its own `ACK`.
